// File: rtl/mem_req_queue.sv
// mem_req_queue: request FIFO and one-at-a-time sequencer in front of the PSRAM QPI controller (memCtrl).
// Build option MEMQ_WRITE_COALESCE_EN merges a write into the youngest queued write to the same address.
module mem_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
) (
  input  logic              i_clkRAM,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_idle,
  output logic              o_overflow,
  output logic              o_mem_cs,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_busy,
  input  logic              i_mem_dataReady,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;
  state_t state_reg;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              we_mem   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  tail_ptr;
  logic [PTR_W:0]    count_reg;
  logic [PTR_W:0]    count_next;
  logic [DATA_W-1:0] cap_reg;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              coalesce;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);
  assign tail_ptr = wr_ptr_reg - PTR_W'(1);
  assign pop      = (state_reg == S_IDLE) && !empty;

`ifdef MEMQ_WRITE_COALESCE_EN
  // The head entry is never merged into while it is leaving the queue.
  assign coalesce = i_req && i_we && !empty && we_mem[tail_ptr] &&
                    (addr_mem[tail_ptr] == i_addr) &&
                    !(pop && (count_reg == ONE_CNT));
`else
  assign coalesce = 1'b0;
`endif

  // Full is judged on the current count, so a same-cycle pop cannot rescue a push.
  assign push = i_req && !full && !coalesce;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + ONE_CNT;
      2'b01:   count_next = count_reg - ONE_CNT;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge i_clkRAM) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= i_addr;
      data_mem[wr_ptr_reg] <= i_wdata;
      we_mem[wr_ptr_reg]   <= i_we;
    end else if (coalesce) begin
      data_mem[tail_ptr] <= i_wdata;
    end
  end

  assign o_idle = empty && (state_reg == S_IDLE) && !o_rvalid;

  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      cap_reg     <= '0;
      o_ready     <= 1'b1;
      o_rvalid    <= 1'b0;
      o_rdata     <= '0;
      o_overflow  <= 1'b0;
      o_mem_cs    <= 1'b1;
      o_mem_write <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      count_reg <= count_next;
      o_ready   <= (count_next != FULL_CNT);
      o_rvalid  <= 1'b0;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (i_req && full && !coalesce) begin
        o_overflow <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (pop) begin
            o_mem_addr  <= addr_mem[rd_ptr_reg];
            o_mem_write <= we_mem[rd_ptr_reg];
            o_mem_wdata <= data_mem[rd_ptr_reg];
            o_mem_cs    <= 1'b0;
            rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
            state_reg   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_mem_cs  <= 1'b1;
          state_reg <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_mem_busy) begin
            state_reg <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_mem_dataReady) begin
            cap_reg <= i_mem_rdata;
          end
          if (!i_mem_busy) begin
            state_reg <= S_IDLE;
            // A read ends with a result even if memCtrl never flagged dataReady.
            if (!o_mem_write) begin
              o_rvalid <= 1'b1;
              o_rdata  <= i_mem_dataReady ? i_mem_rdata : cap_reg;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed and randomized checks of mem_req_queue against a request-order
// reference model, with a cycle-level memCtrl responder driving busy/dataReady.
`timescale 1ns/1ps
module tb_mem_req_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        ready, rvalid, idle, overflow, mem_cs, mem_write;
  logic [7:0]  rdata, mem_wdata;
  logic [23:0] mem_addr;
  logic        mem_busy = 1'b0;
  logic        mem_dr = 1'b0;
  logic [7:0]  mem_rd = '0;

  always #5 clk = ~clk;

  mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(24), .DATA_W(8)) dut (
    .i_clkRAM(clk), .reset(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_ready(ready), .o_rvalid(rvalid), .o_rdata(rdata), .o_idle(idle), .o_overflow(overflow),
    .o_mem_cs(mem_cs), .o_mem_write(mem_write), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_busy(mem_busy), .i_mem_dataReady(mem_dr), .i_mem_rdata(mem_rd)
  );

  typedef struct packed { logic we; logic [23:0] addr; logic [7:0] data; } req_t;

  req_t        q[$];          // accepted, not yet issued
  req_t        dut_iss[$];    // what the DUT actually put on the memory port
  logic [7:0]  exp_rd[$];     // expected read results in request order
  logic [7:0]  rd_log[$];
  logic [7:0]  ref_mem [logic [23:0]];
  logic [7:0]  dev_mem [logic [23:0]];
  int          total = 0, bad = 0;
  bit          outstanding = 0, ovf_exp = 0, exp_rvalid = 0, exp_mwrite = 0, cur_wr = 0, cur_we = 0;
  logic [7:0]  last_rdata = '0, exp_mwdata = '0;
  logic [23:0] exp_maddr = '0, cur_addr = '0;
  int          mc_ph = 0, mc_ack = 0, mc_busy = 0;
  int          force_ack = -1, force_busy = -1;
  int          cs_low_cnt = 0, rvalid_cnt = 0;

  function automatic logic [7:0] dflt(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] dev_rd(input logic [23:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: predict, take the edge, update model and memCtrl responder, then compare.
  task automatic step();
    bit   full_pre, pop_exp, coal, acc, done_edge;
    req_t head, t;
    full_pre  = (q.size() == DEPTH);
    pop_exp   = !outstanding && (q.size() > 0);
    done_edge = (mc_ph == 4);
    coal      = 0;
`ifdef MEMQ_WRITE_COALESCE_EN
    if (req && we && q.size() > 0 && q[q.size()-1].we && q[q.size()-1].addr == addr &&
        !(pop_exp && q.size() == 1)) coal = 1;
`endif
    acc = req && (coal || !full_pre);
    @(posedge clk);
    #1;
    exp_rvalid = 0;
    if (done_edge) begin
      outstanding = 0;
      if (!cur_we) begin
        exp_rvalid = 1;
        if (exp_rd.size() > 0) last_rdata = exp_rd.pop_front();
      end
    end
    if (req && !acc) ovf_exp = 1;
    head = '0;
    if (pop_exp) head = q.pop_front();
    if (acc) begin
      if (we) ref_mem[addr] = wdata;
      else exp_rd.push_back(ref_rd(addr));
      if (coal) begin
        t = q[q.size()-1];
        t.data = wdata;
        q[q.size()-1] = t;
      end else begin
        q.push_back({we, addr, wdata});
      end
    end
    if (pop_exp) begin
      outstanding = 1;
      cur_we      = head.we;
      exp_maddr   = head.addr;
      exp_mwrite  = head.we;
      if (head.we) exp_mwdata = head.data;
      cur_wr      = mem_write;
      cur_addr    = mem_addr;
      if (mem_write) dev_mem[mem_addr] = mem_wdata;
      mc_ph  = 1;
      mc_ack = (force_ack >= 0) ? force_ack : int'($urandom_range(0, 2));
      mc_busy = (force_busy > 0) ? force_busy : int'($urandom_range(1, 5));
    end else if (mc_ph == 1 || mc_ph == 2) begin
      if (mc_ack > 0) begin mc_ack--; mc_ph = 2; end
      else mc_ph = 3;
    end else if (mc_ph == 3) begin
      mc_busy--;
      if (mc_busy == 0) mc_ph = 4;
    end else if (mc_ph == 4) begin
      mc_ph = 0;
    end
    mem_busy = (mc_ph == 3);
    mem_dr   = (mc_ph == 4) && !cur_wr;
    mem_rd   = mem_dr ? dev_rd(cur_addr) : 8'($urandom);

    chk("mem_cs", 32'(mem_cs), 32'(!pop_exp));
    chk("mem_addr", 32'(mem_addr), 32'(exp_maddr));
    chk("mem_write", 32'(mem_write), 32'(exp_mwrite));
    if (exp_mwrite) chk("mem_wdata", 32'(mem_wdata), 32'(exp_mwdata));
    chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("rdata", 32'(rdata), 32'(last_rdata));
    chk("ready", 32'(ready), 32'(q.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(ovf_exp));
    chk("idle", 32'(idle), 32'(q.size() == 0 && !outstanding && !exp_rvalid));
    if (mem_cs === 1'b0) begin
      cs_low_cnt++;
      dut_iss.push_back({mem_write, mem_addr, mem_wdata});
    end
    if (rvalid === 1'b1) begin
      rvalid_cnt++;
      rd_log.push_back(rdata);
    end
  endtask

  task automatic push(input logic w, input logic [23:0] a, input logic [7:0] d);
    req = 1; we = w; addr = a; wdata = d;
    step();
    req = 0;
  endtask

  task automatic idle_cycles(input int n);
    req = 0;
    repeat (n) step();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    req = 0;
    while ((q.size() > 0 || outstanding || exp_rvalid) && n < limit) begin
      step();
      n++;
    end
    chk("drain_done", 32'(q.size() + int'(outstanding) + int'(exp_rvalid)), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    req = 0;
    #1;
    chk("rst_mem_cs", 32'(mem_cs), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    q.delete(); exp_rd.delete();
    outstanding = 0; ovf_exp = 0; exp_rvalid = 0; last_rdata = '0;
    exp_maddr = '0; exp_mwrite = 0; exp_mwdata = '0; mc_ph = 0;
    mem_busy = 0; mem_dr = 0; mem_rd = '0;
    ref_mem.delete();
    foreach (dev_mem[k]) ref_mem[k] = dev_mem[k];
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int c0, r0, i0, n10;
    logic [7:0] d10[$];
    #2;
    do_reset();
    idle_cycles(2);

    // Single write with a long busy window.
    force_ack = 1; force_busy = 20;
    c0 = cs_low_cnt; r0 = rvalid_cnt;
    push(1'b1, 24'h00AAAA, 8'hF0);
    chk("t2_ready_after_push", 32'(ready), 32'd1);
    step();
    chk("t2_cs_low_n2", 32'(mem_cs), 32'd0);
    drain(100);
    chk("t2_cs_pulses", 32'(cs_low_cnt - c0), 32'd1);
    chk("t2_no_rvalid", 32'(rvalid_cnt - r0), 32'd0);
    chk("t2_idle", 32'(idle), 32'd1);

    // Single read; memory returns 5A.
    force_busy = 6;
    ref_mem[24'h00AAAA] = 8'h5A; dev_mem[24'h00AAAA] = 8'h5A;
    c0 = cs_low_cnt; r0 = rvalid_cnt;
    push(1'b0, 24'h00AAAA, 8'h00);
    drain(100);
    chk("t3_rvalid_pulses", 32'(rvalid_cnt - r0), 32'd1);
    chk("t3_rdata", 32'(rdata), 32'h5A);
    chk("t3_cs_pulses", 32'(cs_low_cnt - c0), 32'd1);

    // Five reads pushed behind a long write: fourth fills, fifth overflows.
    for (int i = 1; i <= 5; i++) begin
      ref_mem[24'h000100 + 24'(i)] = 8'(i);
      dev_mem[24'h000100 + 24'(i)] = 8'(i);
    end
    force_busy = 20;
    push(1'b1, 24'h000200, 8'h77);
    idle_cycles(1);
    rd_log.delete();
    r0 = rvalid_cnt;
    for (int i = 1; i <= 5; i++) begin
      push(1'b0, 24'h000100 + 24'(i), 8'h00);
      if (i == 4) chk("t4_ready_full", 32'(ready), 32'd0);
    end
    chk("t4_overflow", 32'(overflow), 32'd1);
    force_busy = 4;
    drain(300);
    chk("t4_rvalid_count", 32'(rvalid_cnt - r0), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("t4_rdata_order", 32'((k < rd_log.size()) ? rd_log[k] : 8'hxx), 32'(k + 1));

    // Reset while a read is in its busy phase with two more queued.
    force_ack = 1; force_busy = 30;
    push(1'b0, 24'h000120, 8'h00);
    idle_cycles(1);
    push(1'b1, 24'h000130, 8'h33);
    push(1'b0, 24'h000131, 8'h00);
    idle_cycles(4);
    do_reset();
    c0 = cs_low_cnt; r0 = rvalid_cnt;
    idle_cycles(20);
    chk("t5_no_rvalid", 32'(rvalid_cnt - r0), 32'd0);
    chk("t5_no_issue", 32'(cs_low_cnt - c0), 32'd0);
    chk("t5_idle", 32'(idle), 32'd1);

    // Two writes to the same address queued behind a busy write.
    force_busy = 10;
    push(1'b1, 24'h000300, 8'h99);
    idle_cycles(1);
    i0 = dut_iss.size();
    push(1'b1, 24'h000010, 8'h11);
    push(1'b1, 24'h000010, 8'h22);
    drain(200);
    n10 = 0;
    for (int k = i0; k < dut_iss.size(); k++)
      if (dut_iss[k].addr == 24'h000010) begin n10++; d10.push_back(dut_iss[k].data); end
`ifdef MEMQ_WRITE_COALESCE_EN
    chk("t6_issue_count", 32'(n10), 32'd1);
    chk("t6_issue_data", 32'((d10.size() > 0) ? d10[0] : 8'hxx), 32'h22);
`else
    chk("t6_issue_count", 32'(n10), 32'd2);
    chk("t6_first_data", 32'((d10.size() > 0) ? d10[0] : 8'hxx), 32'h11);
    chk("t6_second_data", 32'((d10.size() > 1) ? d10[1] : 8'hxx), 32'h22);
`endif
    push(1'b0, 24'h000010, 8'h00);
    drain(100);
    chk("t6_readback", 32'(rdata), 32'h22);

    // Randomized traffic over a small address set with random memCtrl latencies.
    force_ack = -1; force_busy = -1;
    for (int n = 0; n < 800; n++) begin
      req = ($urandom_range(0, 99) < 55);
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       addr = 24'h000010;
        1:       addr = 24'h000011;
        2:       addr = 24'h000020;
        default: addr = 24'($urandom_range(0, 255)) << 4;
      endcase
      wdata = 8'($urandom);
      step();
    end
    drain(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
